// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - unified memory port arbiter for fetch and load/store requesters (optional ARB_ROUND_ROBIN_EN)
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W/8-1:0] d_we,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_req,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W/8-1:0] m_we,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                busy
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   state_t state, state_nx;
   owner_t owner, owner_nx;
   logic   resp;
   logic   issue;
   logic   pick_d;

`ifdef ARB_ROUND_ROBIN_EN
   owner_t last_grant;

   // Remember who won the most recent grant so a tie goes to the other side.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= OWN_I;
      end else if (m_req) begin
         last_grant <= owner_nx;
      end
   end
`endif

   // State and owner registers; reset drops any outstanding transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         owner <= OWN_I;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
      end
   end

   // Arbitration, request forwarding, response routing and next state.
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      m_req    = 1'b0;
      m_addr   = '0;
      m_we     = '0;
      m_wdata  = '0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
      i_rdata  = '0;
      d_rdata  = '0;
      pick_d   = d_req;

      // A response only counts while a transaction is outstanding.
      resp  = (state == S_WAIT) && m_rvalid;
      // The port frees up on the response cycle, allowing back-to-back issue.
      issue = (state == S_IDLE) || resp;

      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         pick_d = (last_grant == OWN_I);
`else
         // Load/store belongs to an older instruction, so it always wins.
         pick_d = 1'b1;
`endif
      end

      if (resp) begin
         if (owner == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
         end else begin
            i_rvalid = 1'b1;
            i_rdata  = m_rdata;
         end
      end

      if (issue) begin
         if (i_req || d_req) begin
            m_req    = 1'b1;
            state_nx = S_WAIT;
            if (pick_d) begin
               d_gnt    = 1'b1;
               m_addr   = d_addr;
               m_we     = d_we;
               m_wdata  = d_wdata;
               owner_nx = OWN_D;
            end else begin
               i_gnt    = 1'b1;
               m_addr   = i_addr;
               owner_nx = OWN_I;
            end
         end else begin
            state_nx = S_IDLE;
         end
      end

      // Nothing handshakes while reset is held.
      if (reset) begin
         i_gnt    = 1'b0;
         d_gnt    = 1'b0;
         m_req    = 1'b0;
         i_rvalid = 1'b0;
         d_rvalid = 1'b0;
         i_rdata  = '0;
         d_rdata  = '0;
      end
   end

   assign busy = (state == S_WAIT);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the RV32I core between the instruction-fetch requester and the load/store requester. The block arbitrates one access at a time, forwards the winner's request to memory, tracks the single outstanding transaction, and routes the memory response back to its owner. It sits between the CPU front end and the memory block, so a unified-memory build can replace the split instruction/data memories.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  ADDR_W  fetch address; stable while i_req is high
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch response valid
- i_rdata  out  DATA_W  fetch response data
- d_req  in  1  load/store request; held until d_gnt
- d_addr  in  ADDR_W  data address
- d_we  in  DATA_W/8  byte write enables; 0 means read
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid; also sent for stores, as a write ack
- d_rdata  out  DATA_W  load data
- m_req  out  1  one-cycle memory request strobe
- m_addr  out  ADDR_W  memory address
- m_we  out  DATA_W/8  memory byte enables
- m_wdata  out  DATA_W  memory write data
- m_rvalid  in  1  memory response/ack, at least 1 cycle after m_req
- m_rdata  in  DATA_W  memory read data
- busy  out  1  a transaction is outstanding

## Operation
- State machine with two states:
  - IDLE: no transaction outstanding.
  - WAIT: one transaction outstanding; `owner` register holds I or D.
- Issue condition: state == IDLE, or state == WAIT with m_rvalid high. Back-to-back issue on the response cycle is allowed.
- On issue with any request pending:
  - Pick the winner by the arbitration policy (see Configuration).
  - Assert the winner's gnt and m_req in the same cycle.
  - Drive m_addr, m_we and m_wdata from the winner. For a fetch winner, m_we = 0 and m_wdata = 0.
  - Register owner = winner; go to (or stay in) WAIT.
- On issue with no request pending: m_req = 0, no gnt; state goes to IDLE.
- gnt, m_req and the m_* fields are combinational from state and the req inputs. At most one gnt is high per cycle.
- Response routing: in WAIT with m_rvalid, raise the owner's rvalid and drive its rdata = m_rdata.
  - The non-owner's rvalid stays 0.
  - The non-owner's rdata is driven to 0.
- m_rvalid in IDLE is ignored: no rvalid is raised and the state does not change.
- busy = (state == WAIT).

## Timing
- Reset (synchronous, takes effect at clk edge):
  - state = IDLE, owner = I, last_grant = I.
  - While reset is high, i_gnt, d_gnt, m_req, i_rvalid and d_rvalid are all forced to 0.
- Latency:
  - Request to grant: 0 cycles when the arbiter is free.
  - Grant to rvalid: equal to the memory latency, at least 1 cycle.
- Throughput: one transaction per memory-latency period. With 1-cycle memory, a grant every cycle, since each issue coincides with the previous response.
- A requester may drop req in the cycle after gnt. A req that is never granted must stay held; withdrawing it is illegal.
- Reset mid-transaction: the outstanding response is discarded. A late m_rvalid arrives in IDLE and is ignored.
- Simultaneous i_req and d_req: exactly one is granted; the other waits for a later issue cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both request in the same issue cycle, grant the one that was not last_grant.
  - last_grant updates on every grant.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, data over fetch. The load/store belongs to an older instruction.
  - last_grant is not implemented.
  - Fetch may starve under continuous d_req; this is accepted.

## Test plan
- Fetch only, 1-cycle memory: i_req, i_addr=0x100; memory returns 0x00500093 → i_gnt and m_req in cycle 0, m_addr=0x100, m_we=0; i_rvalid=1, i_rdata=0x00500093 in cycle 1; d_rvalid stays 0.
- Store then load, 2-cycle memory: d_req, d_we=4'b1111, d_addr=0x2000, d_wdata=0xDEADBEEF, then a read of 0x2000 → second d_gnt only on the first ack cycle; d_rdata=0xDEADBEEF two cycles later; busy high throughout.
- Simultaneous i_req and d_req for 4 cycles, 1-cycle memory: with macro, grants alternate D,I,D,I after reset (last_grant = I); without macro, d_gnt every cycle and i_gnt never.
- Back-to-back fetches, 1-cycle memory, addresses 0x0,0x4,0x8: i_gnt high three consecutive cycles; i_rvalid in the three following cycles with data in order.
- Reset mid-transaction: grant a load, assert reset for 1 cycle before m_rvalid, then deliver m_rvalid → d_rvalid stays 0, busy=0 after reset, next i_req granted immediately.
- No requests, stray m_rvalid=1 in IDLE → no rvalid, no gnt, state remains IDLE.
